// File: rtl/ahb_arbiter.sv
// ahb_arbiter: AHB bus arbiter with burst locking, parked grant and registered Hmaster.
// Define AHB_ARB_ROUND_ROBIN_EN for rotating priority; otherwise the lowest-index requester wins.
module ahb_arbiter #(
    parameter int NUM_MASTERS = 4,
    localparam int MW = $clog2(NUM_MASTERS)
) (
    input  logic                   Hclk,
    input  logic                   Hreset,
    input  logic [NUM_MASTERS-1:0] Hreq,
    input  logic                   Hready,
    input  logic [1:0]             Htrans,
    input  logic [2:0]             Hburst,
    output logic [NUM_MASTERS-1:0] Hgrant,
    output logic [MW-1:0]          Hmaster
);
    localparam logic [1:0] BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;

    logic [3:0]             cnt;
    logic [3:0]             len_m1;
    logic                   locked;
    logic [MW-1:0]          gidx;
    logic [MW-1:0]          nidx;
    logic [NUM_MASTERS-1:0] rot;

    always_comb begin
        len_m1 = Hburst[2:1] == 2'b01 ? 4'd3 : Hburst[2:1] == 2'b10 ? 4'd7 :
                 Hburst[2:1] == 2'b11 ? 4'd15 : 4'd0;
        locked = Htrans == BUSY || (Htrans == NONSEQ && Hburst != 3'b000) ||
                 (Htrans == SEQ && Hburst == 3'b001) || (Htrans == SEQ && cnt > 4'd1);
    end

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_MASTERS; i++)
            if (Hgrant[i]) gidx = MW'(i);
    end

    // rot[k] is the request of master (gidx+1+k) mod NUM_MASTERS, so rot[0] has top priority
    assign rot = (Hreq >> (int'(gidx) + 1)) | (Hreq << (NUM_MASTERS - 1 - int'(gidx)));

    always_comb begin
        nidx = gidx;
`ifdef AHB_ARB_ROUND_ROBIN_EN
        for (int k = NUM_MASTERS - 1; k >= 0; k--)
            if (rot[k]) nidx = MW'((int'(gidx) + 1 + k) % NUM_MASTERS);
`else
        for (int k = NUM_MASTERS - 1; k >= 0; k--)
            if (Hreq[k]) nidx = MW'(k);
`endif
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            Hgrant  <= NUM_MASTERS'(1);
            Hmaster <= '0;
            cnt     <= '0;
        end else if (Hready) begin
            Hmaster <= gidx;
            if (!locked && Hreq != '0) Hgrant <= NUM_MASTERS'(1) << nidx;
            if (Htrans == NONSEQ && Hburst != 3'b001) cnt <= len_m1;
            else if (Htrans == SEQ && cnt != 4'd0) cnt <= cnt - 4'd1;
        end
    end
endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: vector table plus hand sequences; expectations queued per step and compared after the edge.
module tb_ahb_arbiter;
    localparam int N = 4;
`ifdef AHB_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam logic [1:0] ID = 2'b00, BZ = 2'b01, NS = 2'b10, SQ = 2'b11;

    logic         Hclk = 1'b0;
    logic         Hreset = 1'b1;
    logic [N-1:0] Hreq = '0;
    logic         Hready = 1'b1;
    logic [1:0]   Htrans = ID;
    logic [2:0]   Hburst = 3'b000;
    logic [N-1:0] Hgrant;
    logic [1:0]   Hmaster;

    int checks = 0;
    int failures = 0;
    int step_no = 0;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] m;
    } exp_t;

    typedef struct packed {
        logic [3:0] req;
        logic       rdy;
        logic [1:0] trans;
        logic [2:0] burst;
        logic [3:0] g_rr;
        logic [3:0] g_fp;
        logic [1:0] m_rr;
        logic [1:0] m_fp;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    ahb_arbiter #(.NUM_MASTERS(N)) dut (
        .Hclk(Hclk), .Hreset(Hreset), .Hreq(Hreq), .Hready(Hready),
        .Htrans(Htrans), .Hburst(Hburst), .Hgrant(Hgrant), .Hmaster(Hmaster)
    );

    always #5 Hclk = ~Hclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, step_no, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [3:0] req, input logic rdy,
                        input logic [1:0] trans, input logic [2:0] burst,
                        input logic [3:0] g, input logic [1:0] m);
        exp_t e;
        Hreset = rst; Hreq = req; Hready = rdy; Htrans = trans; Hburst = burst;
        sb.push_back('{g: g, m: m});
        @(posedge Hclk);
        #1;
        step_no++;
        e = sb.pop_front();
        check("grant", 32'(Hgrant), 32'(e.g));
        check("master", 32'(Hmaster), 32'(e.m));
        check("onehot", 32'($onehot(Hgrant)), 32'd1);
    endtask

    function automatic vec_t v(input logic [3:0] req, input logic rdy, input logic [1:0] trans,
                               input logic [2:0] burst, input logic [3:0] g_rr, input logic [3:0] g_fp,
                               input logic [1:0] m_rr, input logic [1:0] m_fp);
        return '{req: req, rdy: rdy, trans: trans, burst: burst,
                 g_rr: g_rr, g_fp: g_fp, m_rr: m_rr, m_fp: m_fp};
    endfunction

    initial begin
        // single owner, then one-at-a-time singles
        vecs.push_back(v(4'b0001, 1, NS, 3'd0, 4'b0001, 4'b0001, 0, 0));
        vecs.push_back(v(4'b0001, 1, NS, 3'd0, 4'b0001, 4'b0001, 0, 0));
        vecs.push_back(v(4'b0010, 1, NS, 3'd0, 4'b0010, 4'b0010, 0, 0));
        vecs.push_back(v(4'b0100, 1, NS, 3'd0, 4'b0100, 4'b0100, 1, 1));
        vecs.push_back(v(4'b1000, 1, NS, 3'd0, 4'b1000, 4'b1000, 2, 2));
        vecs.push_back(v(4'b0000, 1, ID, 3'd0, 4'b1000, 4'b1000, 3, 3));
        // master 0 INCR4 with master 1 waiting
        vecs.push_back(v(4'b0001, 1, ID, 3'd0, 4'b0001, 4'b0001, 3, 3));
        vecs.push_back(v(4'b0011, 1, NS, 3'd3, 4'b0001, 4'b0001, 0, 0));
        vecs.push_back(v(4'b0011, 1, SQ, 3'd3, 4'b0001, 4'b0001, 0, 0));
        vecs.push_back(v(4'b0011, 1, SQ, 3'd3, 4'b0001, 4'b0001, 0, 0));
        vecs.push_back(v(4'b0011, 1, SQ, 3'd3, 4'b0010, 4'b0001, 0, 0));
        vecs.push_back(v(4'b0000, 1, ID, 3'd0, 4'b0010, 4'b0001, 1, 0));
        // master 1 INCR4 stalled three cycles on beat 2, master 2 waiting
        vecs.push_back(v(4'b0010, 1, NS, 3'd0, 4'b0010, 4'b0010, 1, 0));
        vecs.push_back(v(4'b0110, 1, NS, 3'd3, 4'b0010, 4'b0010, 1, 1));
        vecs.push_back(v(4'b0110, 1, SQ, 3'd3, 4'b0010, 4'b0010, 1, 1));
        vecs.push_back(v(4'b0110, 0, SQ, 3'd3, 4'b0010, 4'b0010, 1, 1));
        vecs.push_back(v(4'b0110, 0, SQ, 3'd3, 4'b0010, 4'b0010, 1, 1));
        vecs.push_back(v(4'b0110, 0, SQ, 3'd3, 4'b0010, 4'b0010, 1, 1));
        vecs.push_back(v(4'b0110, 1, SQ, 3'd3, 4'b0010, 4'b0010, 1, 1));
        vecs.push_back(v(4'b0110, 1, SQ, 3'd3, 4'b0100, 4'b0010, 1, 1));
        vecs.push_back(v(4'b0000, 1, ID, 3'd0, 4'b0100, 4'b0010, 2, 1));
        // master 1 INCR4 with a BUSY beat while master 0 (higher fixed priority) waits
        vecs.push_back(v(4'b0010, 1, NS, 3'd0, 4'b0010, 4'b0010, 2, 1));
        vecs.push_back(v(4'b0011, 1, NS, 3'd3, 4'b0010, 4'b0010, 1, 1));
        vecs.push_back(v(4'b0011, 1, SQ, 3'd3, 4'b0010, 4'b0010, 1, 1));
        vecs.push_back(v(4'b0011, 1, BZ, 3'd3, 4'b0010, 4'b0010, 1, 1));
        vecs.push_back(v(4'b0011, 1, SQ, 3'd3, 4'b0010, 4'b0010, 1, 1));
        vecs.push_back(v(4'b0011, 1, SQ, 3'd3, 4'b0001, 4'b0001, 1, 1));
        vecs.push_back(v(4'b0000, 1, ID, 3'd0, 4'b0001, 4'b0001, 0, 0));
        // master 0 undefined-length INCR holds the bus until IDLE
        vecs.push_back(v(4'b0011, 1, NS, 3'd1, 4'b0001, 4'b0001, 0, 0));
        vecs.push_back(v(4'b0011, 1, SQ, 3'd1, 4'b0001, 4'b0001, 0, 0));
        vecs.push_back(v(4'b0011, 1, SQ, 3'd1, 4'b0001, 4'b0001, 0, 0));
        vecs.push_back(v(4'b0011, 1, ID, 3'd1, 4'b0010, 4'b0001, 0, 0));
        // all masters requesting singles
        vecs.push_back(v(4'b1111, 1, NS, 3'd0, 4'b0100, 4'b0001, 1, 0));
        vecs.push_back(v(4'b1111, 1, NS, 3'd0, 4'b1000, 4'b0001, 2, 0));
        vecs.push_back(v(4'b1111, 1, NS, 3'd0, 4'b0001, 4'b0001, 3, 0));
        vecs.push_back(v(4'b1111, 1, NS, 3'd0, 4'b0010, 4'b0001, 0, 0));
        vecs.push_back(v(4'b1111, 1, NS, 3'd0, 4'b0100, 4'b0001, 1, 0));

        step(1, 4'b0000, 1, ID, 3'd0, 4'b0001, 2'd0);
        step(1, 4'b0101, 1, NS, 3'd0, 4'b0001, 2'd0);
        for (int i = 0; i < vecs.size(); i++)
            step(0, vecs[i].req, vecs[i].rdy, vecs[i].trans, vecs[i].burst,
                 RR ? vecs[i].g_rr : vecs[i].g_fp, RR ? vecs[i].m_rr : vecs[i].m_fp);

        // reset in the middle of master 2's INCR8 aborts the burst and clears the beat counter
        step(0, 4'b0100, 1, NS, 3'd0, 4'b0100, RR ? 2'd2 : 2'd0);
        step(0, 4'b0101, 1, NS, 3'd5, 4'b0100, 2'd2);
        step(0, 4'b0101, 1, SQ, 3'd5, 4'b0100, 2'd2);
        step(1, 4'b0101, 1, SQ, 3'd5, 4'b0001, 2'd0);
        step(0, 4'b0100, 1, SQ, 3'd5, 4'b0100, 2'd0);
        step(0, 4'b0000, 1, ID, 3'd0, 4'b0100, 2'd2);

        // a request dropped before the arbitration point is never granted; owner keeps grant after dropping Hreq
        step(0, 4'b0110, 1, NS, 3'd3, 4'b0100, 2'd2);
        step(0, 4'b0100, 1, SQ, 3'd3, 4'b0100, 2'd2);
        step(0, 4'b0000, 1, SQ, 3'd3, 4'b0100, 2'd2);
        step(0, 4'b0000, 1, SQ, 3'd3, 4'b0100, 2'd2);
        step(0, 4'b0000, 1, ID, 3'd0, 4'b0100, 2'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 4: number of requesting masters (2..16).
REQ-002 Hclk  input  1  bus clock; all state updates on rising edge.
REQ-003 Hreset  input  1  reset; one clock, reset is synchronous and active-high.
REQ-004 Hreq  input  NUM_MASTERS  per-master bus request; bit i = master i.
REQ-005 Hready  input  1  transfer-complete from selected slave; 1 = current beat completes.
REQ-006 Htrans  input  2  transfer type of owning master: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-007 Hburst  input  3  burst type: 000 SINGLE, 001 INCR, 010/011 WRAP4/INCR4, 100/101 WRAP8/INCR8, 110/111 WRAP16/INCR16.
REQ-008 Hgrant  output  NUM_MASTERS  registered one-hot grant.
REQ-009 Hmaster  output  clog2(NUM_MASTERS)  registered index of master owning the address phase.

Function
REQ-010 Hgrant SHALL be exactly one-hot at all times after reset.
REQ-011 Beat length L: 4/8/16 for WRAP/INCR 4/8/16; SINGLE = 1; INCR = undefined length.
REQ-012 Beat counter SHALL load L-1 on Hready=1 with Htrans=NONSEQ and fixed-length Hburst, and decrement on Hready=1 with Htrans=SEQ, saturating at 0.
REQ-013 Bus locked when any holds: Htrans=BUSY; Htrans=NONSEQ with Hburst!=SINGLE; Htrans=SEQ with Hburst=INCR; Htrans=SEQ with counter>1.
REQ-014 Arbitration point: Hready=1 and bus not locked; no grant change at any other cycle.
REQ-015 At an arbitration point with Hreq!=0, next owner SHALL be the first requesting master searching upward, with wrap-around, starting at (current Hmaster+1) mod NUM_MASTERS (round-robin).
REQ-016 Current owner SHALL be re-granted only if no other master requests.
REQ-017 At an arbitration point with Hreq=0, Hgrant SHALL park on the current owner (unchanged).
REQ-018 Hgrant SHALL update on the rising edge ending the arbitration-point cycle (1-cycle latency from request).
REQ-019 Hmaster SHALL take the index of Hgrant on the first rising edge where Hready=1 after Hgrant changes, i.e. one cycle behind Hgrant when Hready=1; held while Hready=0.
REQ-020 A request deasserted before an arbitration point SHALL not receive a grant; a burst owner's Hreq deassertion mid-burst SHALL not remove its grant.
REQ-021 Hready=0 SHALL freeze Hgrant, Hmaster and the beat counter.

Reset
REQ-022 Hreset=1 at a rising edge: Hgrant=1 (master 0), Hmaster=0, beat counter=0, round-robin pointer at master 0.
REQ-023 Reset mid-burst SHALL abort the burst; first arbitration point follows the first cycle after reset release.

Configuration
REQ-024 Macro AHB_ARB_ROUND_ROBIN_EN: defined -> rotating priority per REQ-015; undefined -> fixed priority, lowest-index requesting master wins at every arbitration point (REQ-016 not applied); all locking rules identical.

Verification
REQ-025 After reset, Hreq=0001, Htrans=NONSEQ, Hburst=000, Hready=1 -> Hgrant=0001, Hmaster=0 throughout.
REQ-026 Singles sequentially Hreq=0010, then 0100, then 1000 -> Hgrant 0010/0100/1000 one cycle after each request, Hmaster 1/2/3 one cycle later.
REQ-027 Master 0 INCR4 (NONSEQ + 3 SEQ, Hburst=011) with Hreq=0011 -> Hgrant stays 0001 for all 4 beats, becomes 0010 after last SEQ.
REQ-028 Hreq=1111 continuously with single transfers (round-robin build) -> grants cycle 0001,0010,0100,1000,0001; fixed-priority build -> 0001 forever.
REQ-029 Hready=0 for 3 cycles during INCR4 beat 2 with Hreq=0110 -> Hgrant, Hmaster, counter unchanged; burst completes 4 beats, then handover.
REQ-030 Hreset asserted mid-INCR8 of master 2 -> next edge Hgrant=0001, Hmaster=0.
